bias_loader: RTL and testbench

BIAS_LOADER -- requirements
Module: bias_loader

---
 rtl/bias_loader.sv | 99 +++++++++
 tb/tb_bias_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bias_loader.sv
// Streams DEPTH bias entries into a local memory with a running checksum; 1-cycle registered read port.
// A beat is accepted when valid_i is high in LOAD (ready_o=1). Abort and reset drop the load without a done pulse.
module bias_loader #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             loaded_o,
  output logic [WIDTH-1:0] checksum_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             beat;

  // Abort beats a coincident data beat, so the beat is neither written nor summed.
  assign beat = (state == LOAD) && valid_i && !abort_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      loaded_o   <= 1'b0;
      checksum_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            checksum_o <= '0;
            loaded_o   <= 1'b0;
            ready_o    <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
          end else if (valid_i) begin
            checksum_o <= checksum_o + data_i;
            if (wr_ptr == LAST) begin
              state    <= DONE;
              ready_o  <= 1'b0;
              done_o   <= 1'b1;
              loaded_o <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  // Bias storage carries no reset; contents survive reset and aborted loads.
  always_ff @(posedge clk_i) begin
    if (beat) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rd_data_o <= '0;
    else if (rd_addr_i <= LAST) rd_data_o <= mem[rd_addr_i];
    else rd_data_o <= '0;
  end

endmodule

// File: tb/tb_bias_loader.sv
// Directed bench for bias_loader: full load, gaps, checksum wrap, abort, boundary reads, reset mid-load.
module tb_bias_loader;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o, busy_o, done_o, loaded_o;
  logic [7:0] checksum_o, rd_data_o;
  logic [3:0] rd_addr_i = 4'd0;

  int nchk = 0;
  int nerr = 0;
  int ndone = 0;

  bias_loader #(.DEPTH(10), .WIDTH(8), .AW(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .loaded_o(loaded_o), .checksum_o(checksum_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o === 1'b1) ndone++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      data_i = 8'($urandom);
      @(negedge clk_i);
    end
  endtask

  task automatic start_load();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_ready", ready_o, 1);
    chk("start_sum", checksum_o, 0);
    chk("start_loaded", loaded_o, 0);
  endtask

  task automatic beat(input logic [7:0] d, input logic ab);
    chk("beat_ready", ready_o, 1);
    valid_i = 1'b1;
    data_i  = d;
    abort_i = ab;
    @(negedge clk_i);
    valid_i = 1'b0;
    abort_i = 1'b0;
    data_i  = 8'($urandom);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    rd_addr_i = a;
    @(negedge clk_i);
    chk($sformatf("rd_%0d", a), rd_data_o, exp);
  endtask

  // Checks the DONE cycle and the IDLE cycle after it; call right after the final beat.
  task automatic finish_load(input logic [7:0] exp_sum, input int done_before);
    chk("done_pulse", done_o, 1);
    chk("done_busy", busy_o, 1);
    chk("done_ready", ready_o, 0);
    @(negedge clk_i);
    chk("after_done", done_o, 0);
    chk("after_busy", busy_o, 0);
    chk("after_loaded", loaded_o, 1);
    chk("after_sum", checksum_o, exp_sum);
    chk("done_count", ndone, done_before + 1);
  endtask

  int gaps [10] = '{0, 2, 1, 0, 3, 1, 0, 0, 2, 1};
  int d0;

  initial begin
    // reset values
    #12;
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_loaded", loaded_o, 0);
    chk("rst_sum", checksum_o, 0);
    chk("rst_rd", rd_data_o, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);

    // valid_i and abort_i in IDLE do nothing
    valid_i = 1'b1; abort_i = 1'b1; data_i = 8'hEE;
    @(negedge clk_i);
    valid_i = 1'b0; abort_i = 1'b0;
    chk("idle_valid_ready", ready_o, 0);
    chk("idle_valid_sum", checksum_o, 0);

    // full load 0x01..0x0A
    d0 = ndone;
    start_load();
    for (int i = 0; i < 10; i++) beat(8'(i + 1), 1'b0);
    finish_load(8'h37, d0);
    for (int i = 0; i < 10; i++) rd(4'(i), 8'(i + 1));

    // valid gaps; start_i mid-load is ignored
    d0 = ndone;
    start_load();
    for (int i = 0; i < 10; i++) begin
      idle(gaps[i]);
      if (i == 5) begin
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_ignored_sum", checksum_o, 8'h20 * 5 + 10);
      end
      if (i == 9) chk("no_early_done", ndone, d0);
      beat(8'(8'h20 + i), 1'b0);
    end
    finish_load(8'h6D, d0);
    rd(4'd0, 8'h20);
    rd(4'd9, 8'h29);

    // checksum wrap
    d0 = ndone;
    start_load();
    for (int i = 0; i < 10; i++) beat(8'hFF, 1'b0);
    finish_load(8'hF6, d0);

    // abort coincident with the 5th beat
    d0 = ndone;
    start_load();
    for (int i = 0; i < 4; i++) beat(8'h10, 1'b0);
    beat(8'h10, 1'b1);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", ready_o, 0);
    chk("abort_loaded", loaded_o, 0);
    chk("abort_sum", checksum_o, 8'h40);
    idle(2);
    chk("abort_no_done", ndone, d0);
    rd(4'd4, 8'hFF);
    rd(4'd3, 8'h10);

    // out-of-range reads
    rd(4'd10, 8'h00);
    rd(4'd15, 8'h00);

    // read-before-write on address 3
    d0 = ndone;
    rd_addr_i = 4'd3;
    start_load();
    for (int i = 0; i < 10; i++) begin
      beat(8'(8'hA0 + i), 1'b0);
      if (i == 3) chk("rbw_old", rd_data_o, 8'h10);
      if (i == 4) chk("rbw_new", rd_data_o, 8'hA3);
    end
    finish_load(8'h6D, d0);

    // reset mid-load, then start on the first edge after release
    start_load();
    for (int i = 0; i < 6; i++) beat(8'(8'h30 + i), 1'b0);
    d0 = ndone;
    #2 reset_ni = 1'b0;
    #1;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_ready", ready_o, 0);
    chk("mrst_sum", checksum_o, 0);
    chk("mrst_loaded", loaded_o, 0);
    chk("mrst_rd", rd_data_o, 0);
    @(negedge clk_i);
    chk("mrst_no_done", ndone, d0);
    reset_ni = 1'b1;
    start_load();
    for (int i = 0; i < 10; i++) beat(8'(8'h05 + i), 1'b0);
    finish_load(8'h5F, d0);
    rd(4'd0, 8'h05);
    rd(4'd9, 8'h0E);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
